alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
//
// PURPOSE
// Execute stage consuming the 3-bit ALU_control code produced by the ALU decoder.
// Computes AND/OR/ADD/SUB/SLT on two operands, derives zero/overflow flags and
// flags illegal control codes. Results are buffered in a 2-entry output queue
// behind a valid/ready handshake, so a stalled consumer never loses an operation.
// Sits between the register-file read and the writeback/branch logic.
//
// PARAMETERS
// WIDTH   32   operand/result width in bits (>= 2)
//
// PORTS
// clk          input   1      rising-edge clock
// reset        input   1      synchronous, active-high reset
// in_valid     input   1      operation presented on in_* this cycle
// in_ready     output  1      unit can accept an operation this cycle
// ALU_control  input   3      operation code (encoding below)
// in_a         input   WIDTH  operand A (rs)
// in_b         input   WIDTH  operand B (rt or immediate)
// out_valid    output  1      head-of-queue result is valid
// out_ready    input   1      consumer takes the head result this cycle
// out_result   output  WIDTH  result
// out_zero     output  1      out_result == 0
// out_ovf      output  1      signed overflow (ADD/SUB only)
// out_illegal  output  1      control code was illegal; out_result forced to 0
//
// BEHAVIOUR
// - Clock and reset: single clock clk; reset is synchronous and active-high.
// - Encoding: 000 AND, 001 OR, 010 ADD, 110 SUB (A-B), 111 SLT (signed A<B -> 1, else 0).
// - Illegal codes: 011, 100 and 101, and any code containing X/Z in simulation.
//   For these: result 0, zero=1, ovf=0, illegal=1.
// - Arithmetic: WIDTH-bit two's-complement, modulo 2^WIDTH wrap.
//   - ADD ovf = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
//   - SUB ovf = (a[msb]!=b[msb]) && (diff[msb]!=a[msb]).
//   - ovf=0 for AND/OR/SLT.
//   - SLT must be correct even when A-B overflows.
// - Accept: an operation is accepted when in_valid && in_ready at a clock edge.
//   The result is computed combinationally from the inputs and written into the queue at that edge.
// - Pop: a result is removed when out_valid && out_ready at a clock edge.
// - Queue: 2 entries, FIFO order. count is in 0..2.
//   - out_valid = (count != 0).
//   - in_ready = (count != 2); it does NOT depend on out_ready (no comb path in->out).
// - Latency: a result is visible on out_* exactly 1 cycle after acceptance when the queue was empty.
//   There is no same-cycle bypass.
// - Simultaneous push+pop:
//   - count==1: count stays 1, and the new entry becomes head next cycle.
//   - count==2: push is impossible (in_ready=0); the pop alone frees a slot.
// - Stable output: while out_valid && !out_ready, all out_* hold their values.
// - Reset (including mid-operation): count=0, queue pointers=0, and all out_* reset to 0
//   (out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_illegal=0); in_ready=1 the cycle after reset.
//   Queued results are discarded.
//   in_valid is ignored while reset=1.
// - When out_valid=0, the out_* data outputs read 0.
//
// TESTING
// 1. ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle: result 0x80000000, ovf=1, zero=0.
// 2. SUB 5-5, then SLT 0x80000000 vs 0x00000001 -> result 0 with zero=1; then result 1 with ovf=0.
// 3. ALU_control=011 with a=b=0xFFFFFFFF -> result 0, illegal=1, zero=1, ovf=0.
// 4. out_ready=0, push 3 ops back-to-back:
//    - in_ready drops after 2 accepts, and the 3rd op waits.
//    - Raise out_ready -> results drain in order; the 3rd is accepted the cycle after the first pop.
// 5. Queue count=1, push+pop in the same cycle -> count stays 1, and the outputs show the new op next cycle.
// 6. Assert reset with 2 queued results -> next cycle: out_valid=0, in_ready=1, all out_* = 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: AND/OR/ADD/SUB/SLT with zero/overflow/illegal flags,
// results held in a 2-entry FIFO behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{result: {WIDTH{1'b0}}, zero: 1'b0, ovf: 1'b0, illegal: 1'b0};

    // Unmatched (or unknown) codes fall through to default and are flagged illegal.
    function automatic entry_t alu_eval(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        entry_t           e;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
        sum  = a + b;
        diff = a - b;
        e    = ENTRY_ZERO;
        case (op)
            3'b000: e.result = a & b;
            3'b001: e.result = a | b;
            3'b010: begin
                e.result = sum;
                e.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b110: begin
                e.result = diff;
                e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'b111: e.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == {WIDTH{1'b0}});
        return e;
    endfunction

    entry_t     mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    entry_t     new_entry_s;
    entry_t     head_s;
    logic       push_s;
    logic       pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Evaluate the presented operation.
    always_comb begin
        new_entry_s = alu_eval(ALU_control, in_a, in_b);
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r[0] <= ENTRY_ZERO;
            mem_r[1] <= ENTRY_ZERO;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= new_entry_s;
            end
            wr_ptr_r <= push_s ? ~wr_ptr_r : wr_ptr_r;
            rd_ptr_r <= pop_s  ? ~rd_ptr_r : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-queue view; data outputs read zero whenever the queue is empty.
    always_comb begin
        head_s = ENTRY_ZERO;
        if (count_r != 2'd0) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = ENTRY_ZERO;
        end
    end

    assign out_result  = head_s.result;
    assign out_zero    = head_s.zero;
    assign out_ovf     = head_s.ovf;
    assign out_illegal = head_s.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_alu_exec_unit;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ALU_control;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_ovf;
    logic          out_illegal;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         o;
        logic         il;
    } exp_t;

    exp_t model_q[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALU_control (ALU_control),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: signed 64-bit arithmetic, overflow = result outside the 32-bit signed range.
    function automatic exp_t model_eval(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: begin
                r = sa + sb;
                e.r = r[31:0];
                e.o = (r > MAXS) || (r < MINS);
            end
            3'd6: begin
                r = sa - sb;
                e.r = r[31:0];
                e.o = (r > MAXS) || (r < MINS);
            end
            3'd7: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one clock edge, mirroring its effect in the model using the inputs held across it.
    task automatic step();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
        end else begin
            do_push = in_valid && (model_q.size() < 2);
            do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(model_eval(ALU_control, in_a, in_b));
        end
        chk_en = 1'b1;
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid    = v;
        ALU_control = op;
        in_a        = a;
        in_b        = b;
    endtask

    function automatic logic [63:0] dut_data();
        return {29'd0, out_result, out_zero, out_ovf, out_illegal};
    endfunction

    function automatic logic [63:0] lit(input logic [W-1:0] r, input bit z, input bit o,
                                        input bit il);
        return {29'd0, r, z, o, il};
    endfunction

    // Compare DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        exp_t h;
        if (chk_en) begin
            h = (model_q.size() > 0) ? model_q[0] : exp_t'(0);
            chk("out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, model_q.size() < 2});
            chk("out_data", dut_data(), lit(h.r, h.z, h.o, h.il));
        end
    end

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'h00000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'd1, 32'd1);
        step();
        step();
        chk("reset_state", {62'd0, out_valid, in_ready}, 64'd1);
        chk("reset_data", dut_data(), 64'd0);
        reset = 1'b0;

        // ADD overflow into the sign bit
        drive(1'b1, 3'b010, 32'h7FFFFFFF, 32'h00000001);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("add_ovf", dut_data(), lit(32'h80000000, 1'b0, 1'b1, 1'b0));
        step();

        // SUB to zero, then SLT with overflowing difference
        drive(1'b1, 3'b110, 32'd5, 32'd5);
        step();
        chk("sub_zero", dut_data(), lit(32'd0, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 3'b111, 32'h80000000, 32'h00000001);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("slt_neg", dut_data(), lit(32'd1, 1'b0, 1'b0, 1'b0));
        step();

        // illegal code
        drive(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("illegal", {out_valid, dut_data()}, {1'b1, lit(32'd0, 1'b1, 1'b0, 1'b1)});
        step();

        // backpressure: three ops with consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
        step();
        drive(1'b1, 3'b001, 32'h00001234, 32'h00000F00);
        step();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 3'b110, 32'd3, 32'd5);
        step();
        chk("stall_hold", {in_ready, dut_data()}, {1'b0, lit(32'hF000F000, 1'b0, 1'b0, 1'b0)});
        out_ready = 1'b1;
        step();
        chk("drain_b", {in_ready, dut_data()}, {1'b1, lit(32'h00001F34, 1'b0, 1'b0, 1'b0)});
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("drain_c", {out_valid, dut_data()}, {1'b1, lit(32'hFFFFFFFE, 1'b0, 1'b0, 1'b0)});
        step();
        chk("drained", {63'd0, out_valid}, 64'd0);

        // push+pop with one entry queued
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd1, 32'd2);
        step();
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 32'd0, 32'd0);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("pushpop", {out_valid, dut_data()}, {1'b1, lit(32'd0, 1'b1, 1'b0, 1'b0)});
        step();

        // reset with two queued results
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd7, 32'd8);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("mid_reset", {in_ready, out_valid, dut_data()}, {2'b10, 64'd0});

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), rand_operand(),
                  rand_operand());
            step();
        end
        reset = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
